datamemory_ctrl: RTL and testbench

Handshaked, parametrised data-memory block for the RISC-V datapath, successor to the single-cycle combinational data memory. It owns its byte-lane storage array. It accepts one load/store request at a time over a valid/ready handshake and inserts a configurable number of wait states. It returns a registered, sign- or zero-extended response pulse, and flags misaligned and illegal accesses instead of silently truncating them.

---
 rtl/datamemory_ctrl.sv | 146 ++++++++++++++
 tb/tb_datamemory_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/datamemory_ctrl.sv
// datamemory_ctrl: handshaked byte-lane data memory with wait states, sign/zero-extended loads and fault flags
// Ports: clk/rst_n (async active-low); req_valid/req_ready accept one request;
//        MemRead/MemWrite/a/wd/Funct3 describe the access; rsp_valid pulses one cycle
//        with rd (load result), misaligned and illegal.
module datamemory_ctrl #(
   parameter int DM_ADDRESS  = 9,
   parameter int DATA_W      = 32,
   parameter int WAIT_STATES = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic [DM_ADDRESS-1:0] a,
   input  logic [DATA_W-1:0]     wd,
   input  logic [2:0]            Funct3,
   output logic                  rsp_valid,
   output logic [DATA_W-1:0]     rd,
   output logic                  misaligned,
   output logic                  illegal
);
   localparam int DEPTH = 1 << (DM_ADDRESS - 2);

   if (DATA_W != 32) begin : g_bad_data_w
      $error("datamemory_ctrl: DATA_W must be 32");
   end
   if (DM_ADDRESS < 3) begin : g_bad_addr
      $error("datamemory_ctrl: DM_ADDRESS must be at least 3");
   end
   if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
      $error("datamemory_ctrl: WAIT_STATES must be 0..15");
   end

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [DM_ADDRESS-1:0] a_q;
   logic [DATA_W-1:0]     wd_q;
   logic [2:0]            f3_q;
   logic                  rd_en_q, wr_en_q;
   logic                  rsp_q, rsp_d, mis_q, mis_d, ill_q, ill_d;
   logic [DATA_W-1:0]     rd_q, rd_d;
   logic [DATA_W-1:0]     mem [DEPTH];

   logic              accept, ld_f3_ok, st_f3_ok, ill, mis, commit;
   logic [DATA_W-1:0] word, ld_data, wdata;
   logic [7:0]        byte_v;
   logic [15:0]       half_v;
   logic [3:0]        be;

   assign req_ready  = (state_q == S_IDLE) & rst_n;
   assign accept     = req_valid & req_ready;
   assign rsp_valid  = rsp_q;
   assign rd         = rd_q;
   assign misaligned = mis_q;
   assign illegal    = ill_q;

   // Decode of the latched request; only meaningful during RESP.
   assign word     = mem[a_q[DM_ADDRESS-1:2]];
   assign byte_v   = word[{a_q[1:0], 3'b000} +: 8];
   assign half_v   = a_q[1] ? word[31:16] : word[15:0];
   assign ld_f3_ok = f3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
   assign st_f3_ok = f3_q inside {3'b000, 3'b001, 3'b010};
   assign ill      = (rd_en_q & wr_en_q) | (rd_en_q & ~ld_f3_ok) | (wr_en_q & ~st_f3_ok);
   // Alignment only matters for a legal access; illegal wins so at most one flag is set.
   assign mis      = ~ill & (rd_en_q | wr_en_q) &
                     (((f3_q[1:0] == 2'b01) & a_q[0]) | ((f3_q[1:0] == 2'b10) & |a_q[1:0]));
   // Funct3[2] selects zero-extension; Funct3[1] a full word, Funct3[0] a half.
   assign ld_data  = f3_q[1] ? word :
                     f3_q[0] ? {{16{~f3_q[2] & half_v[15]}}, half_v} :
                               {{24{~f3_q[2] & byte_v[7]}}, byte_v};
   assign be       = f3_q[1] ? 4'hF : f3_q[0] ? (a_q[1] ? 4'hC : 4'h3) : 4'(4'b0001 << a_q[1:0]);
   assign wdata    = f3_q[1] ? wd_q : f3_q[0] ? {2{wd_q[15:0]}} : {4{wd_q[7:0]}};
   assign commit   = (state_q == S_RESP) & wr_en_q & ~ill & ~mis;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rsp_d   = 1'b0;
      rd_d    = rd_q;
      mis_d   = mis_q;
      ill_d   = ill_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
               cnt_d   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
            end
         end
         S_WAIT: begin
            state_d = (cnt_q == 4'd0) ? S_RESP : S_WAIT;
            cnt_d   = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
         end
         S_RESP: begin
            state_d = S_IDLE;
            rsp_d   = 1'b1;
            rd_d    = (rd_en_q & ~ill & ~mis) ? ld_data : '0;
            mis_d   = mis;
            ill_d   = ill;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rsp_q   <= 1'b0;
         rd_q    <= '0;
         mis_q   <= 1'b0;
         ill_q   <= 1'b0;
         a_q     <= '0;
         wd_q    <= '0;
         f3_q    <= '0;
         rd_en_q <= 1'b0;
         wr_en_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rsp_q   <= rsp_d;
         rd_q    <= rd_d;
         mis_q   <= mis_d;
         ill_q   <= ill_d;
         if (accept) begin
            a_q     <= a;
            wd_q    <= wd;
            f3_q    <= Funct3;
            rd_en_q <= MemRead;
            wr_en_q <= MemWrite;
         end
      end
   end

   // Storage is never reset; a reset during WAIT/RESP leaves state IDLE so nothing commits.
   always_ff @(posedge clk) begin
      if (commit) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[a_q[DM_ADDRESS-1:2]][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end
endmodule

// File: tb/tb_datamemory_ctrl.sv
// tb_datamemory_ctrl: directed self-checking bench for datamemory_ctrl with 0 and 3 wait states
module tb_datamemory_ctrl;
   logic        clk = 1'b0;
   logic        rstn [2];
   logic        vl [2], rr [2], ww [2];
   logic [8:0]  aa [2];
   logic [31:0] wdv [2];
   logic [2:0]  ff [2];
   logic        rdy [2], rsp [2], mis [2], ill [2];
   logic [31:0] rdo [2];

   int cyc = 0;
   int n_tests = 0, n_fail = 0;
   int last_acc, last_low, a1, t0, t1, nb, n_rsp;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   datamemory_ctrl #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_STATES(0)) u_w0 (
      .clk(clk), .rst_n(rstn[0]), .req_valid(vl[0]), .req_ready(rdy[0]),
      .MemRead(rr[0]), .MemWrite(ww[0]), .a(aa[0]), .wd(wdv[0]), .Funct3(ff[0]),
      .rsp_valid(rsp[0]), .rd(rdo[0]), .misaligned(mis[0]), .illegal(ill[0]));

   datamemory_ctrl #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_STATES(3)) u_w3 (
      .clk(clk), .rst_n(rstn[1]), .req_valid(vl[1]), .req_ready(rdy[1]),
      .MemRead(rr[1]), .MemWrite(ww[1]), .a(aa[1]), .wd(wdv[1]), .Funct3(ff[1]),
      .rsp_valid(rsp[1]), .rd(rdo[1]), .misaligned(mis[1]), .illegal(ill[1]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one request on instance u and wait (bounded) for its response.
   task automatic op(input string tag, input int u, input logic r, input logic w,
                     input logic [8:0] ad, input logic [31:0] d, input logic [2:0] f,
                     input logic [31:0] exp_q, input logic exp_m, input logic exp_i);
      int b = 0;
      int lat = 0;
      @(negedge clk);
      while (!rdy[u] && b < 40) begin
         @(negedge clk);
         b++;
      end
      chk({tag, "_ready"}, {31'b0, rdy[u]}, 32'd1);
      vl[u] = 1'b1; rr[u] = r; ww[u] = w; aa[u] = ad; wdv[u] = d; ff[u] = f;
      @(posedge clk);
      #1;
      last_acc = cyc;
      vl[u] = 1'b0;
      last_low = rdy[u] ? 0 : 1;
      while (lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
         if (rsp[u]) break;
         if (!rdy[u]) last_low++;
      end
      chk({tag, "_lat"}, lat, (u == 0) ? 32'd1 : 32'd4);
      chk({tag, "_rd"}, rdo[u], exp_q);
      chk({tag, "_flags"}, {30'b0, mis[u], ill[u]}, {30'b0, exp_m, exp_i});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 2; i++) begin
         rstn[i] = 1'b0; vl[i] = 1'b0; rr[i] = 1'b0; ww[i] = 1'b0;
         aa[i] = '0; wdv[i] = '0; ff[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready_low", {31'b0, rdy[0]}, 32'd0);
      chk("rst_outs", {29'b0, rsp[0], mis[0], ill[0]}, 32'd0);
      chk("rst_rd", rdo[0], 32'd0);
      @(negedge clk);
      rstn[0] = 1'b1; rstn[1] = 1'b1;
      #1;
      chk("ready_after_rst", {31'b0, rdy[0]}, 32'd1);

      op("sw",     0, 0, 1, 9'h010, 32'hDEADBEEF, 3'b010, 32'h0, 0, 0);
      chk("sw_ready_low", last_low, 32'd1);
      op("lw",     0, 1, 0, 9'h010, 32'h0, 3'b010, 32'hDEADBEEF, 0, 0);
      op("sb",     0, 0, 1, 9'h013, 32'hFFFFFF7F, 3'b000, 32'h0, 0, 0);
      op("lw_sb",  0, 1, 0, 9'h010, 32'h0, 3'b010, 32'h7FADBEEF, 0, 0);
      op("lb",     0, 1, 0, 9'h010, 32'h0, 3'b000, 32'hFFFFFFEF, 0, 0);
      op("lbu",    0, 1, 0, 9'h010, 32'h0, 3'b100, 32'h000000EF, 0, 0);
      op("lhu",    0, 1, 0, 9'h012, 32'h0, 3'b101, 32'h00007FAD, 0, 0);
      op("lh",     0, 1, 0, 9'h010, 32'h0, 3'b001, 32'hFFFFBEEF, 0, 0);
      op("lb3",    0, 1, 0, 9'h013, 32'h0, 3'b000, 32'h0000007F, 0, 0);

      op("sw20",   0, 0, 1, 9'h020, 32'hCAFEF00D, 3'b010, 32'h0, 0, 0);
      op("sw_mis", 0, 0, 1, 9'h021, 32'h12345678, 3'b010, 32'h0, 1, 0);
      op("lw20",   0, 1, 0, 9'h020, 32'h0, 3'b010, 32'hCAFEF00D, 0, 0);
      op("lh_mis", 0, 1, 0, 9'h011, 32'h0, 3'b001, 32'h0, 1, 0);
      op("lw20b",  0, 1, 0, 9'h020, 32'h0, 3'b010, 32'hCAFEF00D, 0, 0);
      op("ld_ill", 0, 1, 0, 9'h010, 32'h0, 3'b011, 32'h0, 0, 1);
      op("rw_ill", 0, 1, 1, 9'h020, 32'h0, 3'b010, 32'h0, 0, 1);
      op("rw_mis", 0, 1, 1, 9'h021, 32'h0, 3'b010, 32'h0, 0, 1);
      op("st_ill", 0, 0, 1, 9'h020, 32'h0, 3'b100, 32'h0, 0, 1);
      op("lw20c",  0, 1, 0, 9'h020, 32'h0, 3'b010, 32'hCAFEF00D, 0, 0);
      op("nop",    0, 0, 0, 9'h020, 32'h0, 3'b010, 32'h0, 0, 0);

      op("sw40",   0, 0, 1, 9'h040, 32'h0, 3'b010, 32'h0, 0, 0);
      op("sh",     0, 0, 1, 9'h042, 32'h1234ABCD, 3'b001, 32'h0, 0, 0);
      a1 = last_acc;
      op("lw40",   0, 1, 0, 9'h040, 32'h0, 3'b010, 32'hABCD0000, 0, 0);
      chk("b2b_gap", last_acc - a1, 32'd2);

      op("sw3",    1, 0, 1, 9'h030, 32'h11223344, 3'b010, 32'h0, 0, 0);
      chk("w3_ready_low", last_low, 32'd4);
      op("lw3",    1, 1, 0, 9'h030, 32'h0, 3'b010, 32'h11223344, 0, 0);

      // Held req_valid: second accept only after returning to IDLE.
      t0 = -1; t1 = -1; nb = 0;
      @(negedge clk);
      vl[1] = 1'b1; rr[1] = 1'b0; ww[1] = 1'b0;
      while (t1 < 0 && nb < 40) begin
         @(posedge clk);
         #1;
         nb++;
         if (rsp[1]) begin
            if (t0 < 0) t0 = cyc;
            else t1 = cyc;
         end
      end
      @(negedge clk);
      vl[1] = 1'b0;
      chk("held_gap", t1 - t0, 32'd5);

      op("lw3b",   1, 1, 0, 9'h030, 32'h0, 3'b010, 32'h11223344, 0, 0);
      // Reset during WAIT of a store: discarded, no response.
      @(negedge clk);
      vl[1] = 1'b1; rr[1] = 1'b0; ww[1] = 1'b1; aa[1] = 9'h030; wdv[1] = 32'h55667788; ff[1] = 3'b010;
      @(posedge clk);
      #1;
      vl[1] = 1'b0;
      @(posedge clk);
      #1;
      rstn[1] = 1'b0;
      #1;
      chk("rstw_outs", {29'b0, rsp[1], mis[1], ill[1]}, 32'd0);
      chk("rstw_rd", rdo[1], 32'd0);
      chk("rstw_ready", {31'b0, rdy[1]}, 32'd0);
      @(negedge clk);
      rstn[1] = 1'b1;
      n_rsp = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         n_rsp += int'(rsp[1]);
      end
      chk("rstw_norsp", n_rsp, 32'd0);
      op("lw3_after", 1, 1, 0, 9'h030, 32'h0, 3'b010, 32'h11223344, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
